// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory geometry, reset fetch address, the halt
// encoding and the memory-port controller state encoding.
`timescale 1ns/1ps
package cpu_pkg;

  localparam int          BITS_DATA = 32;
  localparam int          BITS_ADDR = 16;
  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    LS    = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_port_ctrl.sv
// Memory port controller: the single owner of the unified memory port.
// Fetches instructions and hands them to decode over a valid/ready
// handshake, services one load/store at a time between fetches, and stops
// fetching for good when the HALT word is read.
//
// Ports:
//   clk, rst_n       clock (posedge), asynchronous active-low reset
//   mem_addr/wdata/write, mem_rdata
//                    memory side; outputs depend on registered state only
//   instr, instr_pc, instr_valid, instr_ready
//                    fetched instruction towards decode
//   branch_en, branch_target
//                    PC redirect, taken only on the instr handshake cycle
//   ls_req, ls_we, ls_addr, ls_wdata, ls_ack, ls_rdata
//                    load/store request from execute, one-cycle ack
//   halted           sticky halt indication
`timescale 1ns/1ps
module mem_port_ctrl #(
  parameter int                   BITS_DATA = cpu_pkg::BITS_DATA,
  parameter int                   BITS_ADDR = cpu_pkg::BITS_ADDR,
  parameter logic [BITS_ADDR-1:0] RESET_PC  = BITS_ADDR'(cpu_pkg::RESET_PC),
  parameter logic [BITS_DATA-1:0] HALT_WORD = BITS_DATA'(cpu_pkg::HALT_WORD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [BITS_ADDR-1:0] mem_addr,
  output logic [BITS_DATA-1:0] mem_wdata,
  output logic                 mem_write,
  input  logic [BITS_DATA-1:0] mem_rdata,
  output logic [BITS_DATA-1:0] instr,
  output logic [BITS_ADDR-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 branch_en,
  input  logic [BITS_ADDR-1:0] branch_target,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [BITS_ADDR-1:0] ls_addr,
  input  logic [BITS_DATA-1:0] ls_wdata,
  output logic                 ls_ack,
  output logic [BITS_DATA-1:0] ls_rdata,
  output logic                 halted
);

  cpu_pkg::state_t        state_q, state_d;
  logic [BITS_ADDR-1:0]   pc_q, pc_d;
  logic [BITS_DATA-1:0]   instr_q, instr_d;
  logic [BITS_ADDR-1:0]   instr_pc_q, instr_pc_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   ls_ack_q, ls_ack_d;
  logic [BITS_DATA-1:0]   ls_rdata_q, ls_rdata_d;
  logic                   halted_q, halted_d;
  logic                   pending_q, pending_d;
  logic                   ls_we_q, ls_we_d;
  logic [BITS_ADDR-1:0]   ls_addr_q, ls_addr_d;
  logic [BITS_DATA-1:0]   ls_wdata_q, ls_wdata_d;
  logic                   capture;

  // A new request is latched only while fetching/holding, and never in the
  // ack cycle, because execute still holds ls_req high for that one cycle.
  assign capture = ls_req && !pending_q && !ls_ack_q &&
                   ((state_q == cpu_pkg::FETCH) || (state_q == cpu_pkg::HOLD));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    ls_ack_d      = 1'b0;
    ls_rdata_d    = ls_rdata_q;
    halted_d      = halted_q;
    pending_d     = pending_q;
    ls_we_d       = ls_we_q;
    ls_addr_d     = ls_addr_q;
    ls_wdata_d    = ls_wdata_q;

    if (capture) begin
      pending_d  = 1'b1;
      ls_we_d    = ls_we;
      ls_addr_d  = ls_addr;
      ls_wdata_d = ls_wdata;
    end

    case (state_q)
      cpu_pkg::FETCH: begin
        if (mem_rdata == HALT_WORD) begin
          // Halting drops any request, including one captured this cycle.
          state_d   = cpu_pkg::HALT;
          halted_d  = 1'b1;
          pending_d = 1'b0;
        end else begin
          instr_d       = mem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 1'b1;
          state_d       = cpu_pkg::HOLD;
        end
      end
      cpu_pkg::HOLD: begin
        if (instr_valid_q && instr_ready) begin
          instr_valid_d = 1'b0;
          if (branch_en) pc_d = branch_target;
          state_d = pending_q ? cpu_pkg::LS : cpu_pkg::FETCH;
        end
      end
      cpu_pkg::LS: begin
        if (!ls_we_q) ls_rdata_d = mem_rdata;
        ls_ack_d  = 1'b1;
        pending_d = 1'b0;
        state_d   = cpu_pkg::FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= cpu_pkg::FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      ls_ack_q      <= 1'b0;
      ls_rdata_q    <= '0;
      halted_q      <= 1'b0;
      pending_q     <= 1'b0;
      ls_we_q       <= 1'b0;
      ls_addr_q     <= '0;
      ls_wdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      ls_ack_q      <= ls_ack_d;
      ls_rdata_q    <= ls_rdata_d;
      halted_q      <= halted_d;
      pending_q     <= pending_d;
      ls_we_q       <= ls_we_d;
      ls_addr_q     <= ls_addr_d;
      ls_wdata_q    <= ls_wdata_d;
    end
  end

  // Memory side is decoded from state only, so it is steady across the
  // negedge write point. Async reset clears state_q, which drops mem_write
  // at once. While holding, the address stays on the instruction just read.
  always_comb begin
    case (state_q)
      cpu_pkg::LS:   mem_addr = ls_addr_q;
      cpu_pkg::HOLD: mem_addr = instr_pc_q;
      default:       mem_addr = pc_q;
    endcase
  end

  assign mem_write   = (state_q == cpu_pkg::LS) && ls_we_q;
  assign mem_wdata   = ls_wdata_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign ls_ack      = ls_ack_q;
  assign ls_rdata    = ls_rdata_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
`timescale 1ns/1ps
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_en = 1'b0;
  logic [15:0] branch_target = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [15:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        halted;

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ins, rd;
  logic [15:0] pc;

  mem_port_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branch_en(branch_en), .branch_target(branch_target),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .halted(halted)
  );

  always #5 clk = ~clk;

  // Unified memory: async read, write on negedge.
  assign mem_rdata = mem[mem_addr];
  always @(negedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[0] = 32'h0000FFFF;
    mem[1] = 32'h01005555;
    mem[2] = 32'h33331111;
    mem[3] = 32'hFFFFFFFF;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_ready = 1'b0; branch_en = 1'b0; branch_target = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, instr_valid, 1);
  endtask

  // Waits for a valid instruction, returns it and completes one handshake.
  task automatic take(input logic br, input logic [15:0] tgt,
                      output logic [31:0] o_ins, output logic [15:0] o_pc);
    wait_valid("take_valid");
    o_ins = instr;
    o_pc  = instr_pc;
    instr_ready = 1'b1; branch_en = br; branch_target = tgt;
    @(negedge clk);
    instr_ready = 1'b0; branch_en = 1'b0;
  endtask

  // One load/store transaction; decode is kept accepting so it can be serviced.
  task automatic do_ls(input logic we, input logic [15:0] a, input logic [31:0] d,
                       output logic [31:0] o_rd);
    int  n = 0;
    int  writes = 0;
    bit  got = 0;
    o_rd = '0;
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = d; instr_ready = 1'b0;
    @(negedge clk);
    instr_ready = 1'b1;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_write) begin
        writes++;
        check_eq("ls_waddr", mem_addr, a);
        check_eq("ls_wdata", mem_wdata, d);
      end
      if (ls_ack) begin
        got = 1;
        o_rd = ls_rdata;
      end
    end
    ls_req = 1'b0; instr_ready = 1'b0;
    check_eq("ls_ack_seen", got, 1);
    check_eq("ls_nwrites", writes, we ? 1 : 0);
    @(negedge clk);
    check_eq("ls_ack_pulse", ls_ack, 0);
    if (got) check_eq("ls_rdata_hold", ls_rdata, o_rd);
  endtask

  task automatic run_random(input int ncyc);
    logic [15:0] exp_pc;
    logic [31:0] last_ld;
    logic        r_we;
    logic [15:0] r_addr;
    logic [31:0] r_data;
    int idle = 0, wait_cnt = 0, nwr = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w == 32'hFFFFFFFF) w = 32'h7FFFFFFF;
      mem[i] = w; ref_mem[i] = w;
      w = $urandom;
      mem[16'h8000 + i] = w; ref_mem[16'h8000 + i] = w;
    end
    exp_pc = '0; last_ld = '0; r_we = 1'b0; r_addr = '0; r_data = '0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (mem_write) begin
        check_eq("rnd_wr_req", 32'(ls_req && r_we), 1);
        check_eq("rnd_wr_addr", mem_addr, r_addr);
        check_eq("rnd_wr_data", mem_wdata, r_data);
        nwr++;
      end
      if (ls_req) begin
        if (ls_ack) begin
          if (r_we) begin
            check_eq("rnd_st_nwr", nwr, 1);
            check_eq("rnd_st_mem", mem[r_addr], r_data);
            ref_mem[r_addr] = r_data;
          end else begin
            check_eq("rnd_ld_data", ls_rdata, ref_mem[r_addr]);
            last_ld = ref_mem[r_addr];
          end
          ls_req = 1'b0;
        end else begin
          wait_cnt++;
          if (wait_cnt > 60) begin
            check_eq("rnd_ls_timeout", ls_ack, 1);
            ls_req = 1'b0;
          end
        end
      end else begin
        check_eq("rnd_ack_idle", ls_ack, 0);
        check_eq("rnd_rdata_hold", ls_rdata, last_ld);
        if ($urandom_range(0, 5) == 0) begin
          r_we = 1'($urandom % 2);
          r_addr = 16'h8000 | 16'($urandom_range(0, 255));
          r_data = $urandom;
          ls_req = 1'b1; ls_we = r_we; ls_addr = r_addr; ls_wdata = r_data;
          wait_cnt = 0; nwr = 0;
        end
      end
      if (instr_valid) begin
        idle = 0;
        check_eq("rnd_instr", instr, ref_mem[exp_pc]);
        check_eq("rnd_pc", instr_pc, exp_pc);
        instr_ready = 1'($urandom % 2);
        branch_en = ($urandom % 6) == 0;
        branch_target = 16'($urandom_range(0, 255));
        if (instr_ready) exp_pc = branch_en ? branch_target : exp_pc + 16'd1;
      end else begin
        idle++;
        if (idle > 6) begin
          check_eq("rnd_fetch_stall", instr_valid, 1);
          idle = 0;
        end
        instr_ready = 1'($urandom % 2);
        branch_en = 1'($urandom % 2);
        branch_target = 16'($urandom);
      end
    end
    ls_req = 1'b0; instr_ready = 1'b0; branch_en = 1'b0;
  endtask

  logic [31:0] exp_i [3] = '{32'h0000FFFF, 32'h01005555, 32'h33331111};

  initial begin
    logic [31:0] gi [8];
    logic [15:0] gp [8];
    int ng, n, wr;
    bit seen;

    // Reset values
    load_prog();
    #12;
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_instr_pc", instr_pc, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_ls_ack", ls_ack, 0);
    check_eq("rst_ls_rdata", ls_rdata, 0);
    check_eq("rst_mem_write", mem_write, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_mem_addr", mem_addr, 0);

    // Straight-line program ending in HALT
    do_reset();
    instr_ready = 1'b1;
    ng = 0; n = 0; wr = 0;
    while (!halted && n < 30) begin
      @(negedge clk);
      n++;
      if (mem_write) wr++;
      if (instr_valid && ng < 8) begin
        gi[ng] = instr; gp[ng] = instr_pc; ng++;
      end
    end
    instr_ready = 1'b0;
    check_eq("t1_halted", halted, 1);
    check_eq("t1_count", ng, 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("t1_instr", gi[i], exp_i[i]);
      check_eq("t1_pc", gp[i], i);
    end
    check_eq("t1_no_write", wr, 0);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0005; ls_wdata = 32'hABCD0123;
    repeat (4) begin
      @(negedge clk);
      check_eq("t1_halt_addr", mem_addr, 3);
      check_eq("t1_halt_valid", instr_valid, 0);
      check_eq("t1_halt_ack", ls_ack, 0);
      check_eq("t1_halt_write", mem_write, 0);
      check_eq("t1_halt_sticky", halted, 1);
    end
    ls_req = 1'b0;

    // Decode stalls for 5 cycles
    mem[3] = 32'h0;
    do_reset();
    wait_valid("t2_valid");
    repeat (5) begin
      @(negedge clk);
      check_eq("t2_instr", instr, 32'h0000FFFF);
      check_eq("t2_valid_hold", instr_valid, 1);
      check_eq("t2_instr_pc", instr_pc, 0);
      check_eq("t2_mem_addr", mem_addr, 0);
    end
    take(1'b0, 16'h0, ins, pc);
    check_eq("t2_first", ins, 32'h0000FFFF);
    take(1'b0, 16'h0, ins, pc);
    check_eq("t2_next", ins, 32'h01005555);
    check_eq("t2_next_pc", pc, 1);

    // Store then load
    do_reset();
    wait_valid("t3_valid");
    do_ls(1'b1, 16'h0010, 32'hDEADBEEF, rd);
    check_eq("t3_mem", mem[16'h0010], 32'hDEADBEEF);
    do_ls(1'b0, 16'h0010, 32'h0, rd);
    check_eq("t3_load", rd, 32'hDEADBEEF);

    // Branch on handshake; branch outside handshake ignored
    do_reset();
    take(1'b1, 16'h0002, ins, pc);
    check_eq("t4_pc0", pc, 0);
    wait_valid("t4_valid");
    branch_en = 1'b1; branch_target = 16'h0080;
    repeat (3) begin
      @(negedge clk);
      check_eq("t4_hold_pc", instr_pc, 2);
    end
    branch_en = 1'b0;
    take(1'b0, 16'h0, ins, pc);
    check_eq("t4_br_instr", ins, 32'h33331111);
    check_eq("t4_br_pc", pc, 2);
    take(1'b0, 16'h0, ins, pc);
    check_eq("t4_after_pc", pc, 3);

    // Address wrap
    do_reset();
    do_ls(1'b1, 16'hFFFF, 32'h12345678, rd);
    take(1'b1, 16'hFFFF, ins, pc);
    take(1'b0, 16'h0, ins, pc);
    check_eq("t5_top_instr", ins, 32'h12345678);
    check_eq("t5_top_pc", pc, 16'hFFFF);
    take(1'b0, 16'h0, ins, pc);
    check_eq("t5_wrap_instr", ins, 32'h0000FFFF);
    check_eq("t5_wrap_pc", pc, 0);

    // Reset during a store cycle, clk high
    mem[16'h0020] = 32'h11112222;
    do_reset();
    wait_valid("t6_valid");
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0020; ls_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    instr_ready = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (mem_write) seen = 1;
    end
    check_eq("t6_ls_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_wr_drop", mem_write, 0);
    check_eq("t6_addr_rst", mem_addr, 0);
    check_eq("t6_instr_rst", instr, 0);
    @(negedge clk);
    ls_req = 1'b0; instr_ready = 1'b0;
    #1;
    check_eq("t6_mem_kept", mem[16'h0020], 32'h11112222);
    check_eq("t6_ack_rst", ls_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    take(1'b0, 16'h0, ins, pc);
    check_eq("t6_restart_pc", pc, 0);
    check_eq("t6_restart_instr", ins, 32'h0000FFFF);

    // Randomized traffic against the reference model
    run_random(3000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
